pipe_hazard_ctrl: RTL and testbench

- Parametrised pipeline hazard controller for the RISC-V core. Successor to the fixed 5-stage stall priority encoder.
- Generalised to NUM_STAGES stages. Generates per-stage stall, bubble and flush vectors.
- Adds sequential behaviour: deferred (pending) flush capture, a consecutive-stall watchdog, and stall/flush performance counters.
- Sits beside the pipeline registers. Stage 0 is the PC/IF stage; stage NUM_STAGES-1 is WB.

---
 rtl/pipe_hazard_ctrl_if.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
//   master: pipeline side; drives stall_req/flush_req and reads the controls.
//   slave : controller side; reads the requests and drives stall/bubble/flush,
//           flush_pending, stall_timeout and the two performance counters.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned CNT_W      = 32
);
    logic [NUM_STAGES-1:0] stall_req;
    logic [NUM_STAGES-1:0] flush_req;
    logic [NUM_STAGES-1:0] stall;
    logic [NUM_STAGES-1:0] bubble;
    logic [NUM_STAGES-1:0] flush;
    logic                  flush_pending;
    logic                  stall_timeout;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output stall_req, flush_req,
        input  stall, bubble, flush, flush_pending, stall_timeout,
               stall_cycles, flush_count
    );

    modport slave (
        input  stall_req, flush_req,
        output stall, bubble, flush, flush_pending, stall_timeout,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Parametrised pipeline hazard controller.
// Produces per-stage stall/bubble/flush (combinational, 0-cycle latency),
// defers flushes whose requesting stage is frozen, runs a consecutive-stall
// watchdog and counts stall cycles and applied flushes.
// Ports:
//   clk   - core clock
//   rst_n - asynchronous active-low reset
//   bus   - pipe_hazard_ctrl_if slave modport (requests in, controls/status out)
module pipe_hazard_ctrl #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned TIMEOUT    = 1023,
    parameter int unsigned WD_W       = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_hazard_ctrl_if.slave    bus
);
    localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    // Registered state
    logic             pend_vld_q, pend_vld_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
    logic [WD_W-1:0]  wd_cnt_q,   wd_cnt_d;
    logic             timeout_q,  timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Combinational decode
    logic [IDX_W-1:0]      k_c, j_c;
    logic                  has_stall_c, has_flush_c, blocked_c, applied_c;
    logic [NUM_STAGES-1:0] pend_oh_c, f_vec_c;
    logic [NUM_STAGES-1:0] stall_c, bubble_c, flush_c;

    // Highest stall requester k
    always_comb begin
        k_c         = '0;
        has_stall_c = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (bus.stall_req[i]) begin
                k_c         = IDX_W'(i);
                has_stall_c = 1'b1;
            end
        end
    end

    // Effective flush vector; stage 0 cannot kill anything so its bit is masked
    always_comb begin
        pend_oh_c = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            pend_oh_c[i] = pend_vld_q && (pend_idx_q == IDX_W'(i));
        end
        f_vec_c = (bus.flush_req | pend_oh_c) & ~NUM_STAGES'(1);
    end

    // Highest flush source j (pending index participates, so max is implicit)
    always_comb begin
        j_c         = '0;
        has_flush_c = 1'b0;
        for (int i = 1; i < NUM_STAGES; i++) begin
            if (f_vec_c[i]) begin
                j_c         = IDX_W'(i);
                has_flush_c = 1'b1;
            end
        end
        blocked_c = has_flush_c && has_stall_c && (k_c >= j_c);
        applied_c = has_flush_c && !blocked_c;
    end

    // Per-stage control vectors; an applied flush overrides stall/bubble
    always_comb begin
        stall_c  = '0;
        bubble_c = '0;
        flush_c  = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (applied_c) begin
                flush_c[i] = (IDX_W'(i) < j_c);
            end else if (has_stall_c) begin
                stall_c[i]  = (IDX_W'(i) <= k_c);
                bubble_c[i] = (i != 0) && (k_c == IDX_W'(i - 1));
            end
        end
    end

    // Next-state: pending flush, watchdog, counters
    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_idx_d  = pend_idx_q;
        wd_cnt_d    = '0;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (blocked_c) begin
            pend_vld_d = 1'b1;
            pend_idx_d = j_c;
        end else if (applied_c) begin
            pend_vld_d = 1'b0;
            pend_idx_d = '0;
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end

        if (|stall_c) begin
            wd_cnt_d    = (&wd_cnt_q) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (wd_cnt_d >= WD_W'(TIMEOUT)) begin
            timeout_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q  <= 1'b0;
            pend_idx_q  <= '0;
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_idx_q  <= pend_idx_d;
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Controls are forced low while reset is asserted
    assign bus.stall         = rst_n ? stall_c  : '0;
    assign bus.bubble        = rst_n ? bubble_c : '0;
    assign bus.flush         = rst_n ? flush_c  : '0;
    assign bus.flush_pending = pend_vld_q;
    assign bus.stall_timeout = timeout_q;
    assign bus.stall_cycles  = stall_cnt_q;
    assign bus.flush_count   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (NUM_STAGES=5, TIMEOUT=4).
module tb_pipe_hazard_ctrl;
    localparam int unsigned NS  = 5;
    localparam int unsigned CW  = 32;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_failed;

    pipe_hazard_ctrl_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(
        .NUM_STAGES(NS),
        .TIMEOUT   (4),
        .WD_W      (16),
        .CNT_W     (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one active edge and sample just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply requests and let combinational outputs settle
    task automatic drive(input logic [NS-1:0] sr, input logic [NS-1:0] fr);
        bus.stall_req = sr;
        bus.flush_req = fr;
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic [NS-1:0] s,
                             input logic [NS-1:0] b, input logic [NS-1:0] f);
        check({tag, ".stall"},  64'(bus.stall),  64'(s));
        check({tag, ".bubble"}, 64'(bus.bubble), 64'(b));
        check({tag, ".flush"},  64'(bus.flush),  64'(f));
    endtask

    task automatic check_stat(input string tag, input logic fp, input logic to,
                              input int unsigned sc, input int unsigned fc);
        check({tag, ".flush_pending"}, 64'(bus.flush_pending), 64'(fp));
        check({tag, ".stall_timeout"}, 64'(bus.stall_timeout), 64'(to));
        check({tag, ".stall_cycles"},  64'(bus.stall_cycles),  64'(sc));
        check({tag, ".flush_count"},   64'(bus.flush_count),   64'(fc));
    endtask

    initial begin
        n_tests  = 0;
        n_failed = 0;
        rst_n    = 1'b0;
        bus.stall_req = '0;
        bus.flush_req = '0;
        #2;
        check_ctl("reset", '0, '0, '0);
        check_stat("reset", 1'b0, 1'b0, 0, 0);
        // Requests during reset must still give zero controls
        drive(5'b01000, 5'b00100);
        check_ctl("reset_req", '0, '0, '0);
        drive('0, '0);
        step();
        rst_n = 1'b1;

        // Single stall request
        drive(5'b00100, '0);
        check_ctl("single", 5'b00111, 5'b01000, '0);
        step();
        check_stat("single_e1", 1'b0, 1'b0, 1, 0);
        step();
        check_stat("single_e2", 1'b0, 1'b0, 2, 0);

        // Priority across stages
        drive(5'b01010, '0);
        check_ctl("prio_a", 5'b01111, 5'b10000, '0);
        step();
        check_stat("prio_a", 1'b0, 1'b0, 3, 0);
        drive(5'b10000, '0);
        check_ctl("prio_wb", 5'b11111, 5'b00000, '0);
        drive('0, '0);
        check_ctl("idle", '0, '0, '0);
        step();
        check_stat("idle", 1'b0, 1'b0, 3, 0);

        // Unblocked flush overrides stall
        drive(5'b00001, 5'b00100);
        check_ctl("flush_unblk", '0, '0, 5'b00011);
        step();
        check_stat("flush_unblk", 1'b0, 1'b0, 3, 1);

        // Deferred flush
        drive(5'b01000, 5'b00100);
        check_ctl("defer_c0", 5'b01111, 5'b10000, '0);
        step();
        check_stat("defer_c1", 1'b1, 1'b0, 4, 1);
        drive('0, '0);
        check_ctl("defer_c1", '0, '0, 5'b00011);
        step();
        check_stat("defer_c2", 1'b0, 1'b0, 4, 2);

        // Lower request while a higher one is pending is subsumed
        drive(5'b01000, 5'b00100);
        step();
        check_stat("subsume_c1", 1'b1, 1'b0, 5, 2);
        drive('0, 5'b00010);
        check_ctl("subsume", '0, '0, 5'b00011);
        step();
        check_stat("subsume_c2", 1'b0, 1'b0, 5, 3);

        // flush_req[0] kills nothing and is never made pending
        drive('0, 5'b00001);
        check_ctl("flush0", '0, '0, '0);
        step();
        check_stat("flush0", 1'b0, 1'b0, 5, 3);
        drive(5'b00010, 5'b00001);
        check_ctl("flush0_stall", 5'b00011, 5'b00100, '0);
        step();
        check_stat("flush0_stall", 1'b0, 1'b0, 6, 3);
        drive('0, '0);
        step();

        // Watchdog: 3 stalls, gap, then 4 consecutive stalls
        drive(5'b00001, '0);
        for (int i = 0; i < 3; i++) step();
        check_stat("wd_3", 1'b0, 1'b0, 9, 3);
        drive('0, '0);
        step();
        check_stat("wd_gap", 1'b0, 1'b0, 9, 3);
        drive(5'b00001, '0);
        for (int i = 0; i < 3; i++) step();
        check_stat("wd_3b", 1'b0, 1'b0, 12, 3);
        step();
        check_stat("wd_4", 1'b0, 1'b1, 13, 3);
        check_ctl("wd_ctl", 5'b00001, 5'b00010, '0);
        drive('0, '0);
        step();
        check_stat("wd_sticky", 1'b0, 1'b1, 13, 3);

        // Async reset with a pending flush
        drive(5'b01000, 5'b00100);
        step();
        check_stat("pre_rst", 1'b1, 1'b1, 14, 3);
        #1;
        rst_n = 1'b0;
        #1;
        check_ctl("async_rst", '0, '0, '0);
        check_stat("async_rst", 1'b0, 1'b0, 0, 0);
        rst_n = 1'b1;
        drive('0, '0);
        check_ctl("post_rst", '0, '0, '0);
        step();
        check_stat("post_rst", 1'b0, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule
